bcd_timer_updown: RTL and testbench

- Parametrised multi-digit up/down timer counter; successor to the single-digit mod-10 down counter with load, enable and ripple-carry.
- Holds DIGITS packed BCD-style digits. Each digit has its own modulus, so one instance implements an mm:ss or hh:mm timer directly, with no external digit cascading.
- Sits between the timer control FSM (load, enable, direction) and the display decoder (count). Flags terminal and completion back to control.

---
 rtl/bcd_timer_updown.sv | 119 +++++++++++
 tb/tb_bcd_timer_updown.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/bcd_timer_updown.sv
// Multi-digit mixed-radix up/down timer with per-digit modulus, load clamp and done pulse.
// Define BCD_TIMER_AUTO_RELOAD_EN to make down-counting restart from the last loaded value.
module bcd_timer_digit #(
  parameter logic [3:0] MOD = 4'd10
) (
  input  logic       dir_i,
  input  logic       cin_i,
  input  logic [3:0] cur_i,
  input  logic [3:0] ld_i,
  output logic [3:0] nxt_o,
  output logic [3:0] clamp_o,
  output logic       term_o,
  output logic       nterm_o
);
  localparam logic [3:0] MAXV = MOD - 4'd1;

  logic at_max, at_zero;
  assign at_max  = (cur_i == MAXV);
  assign at_zero = (cur_i == 4'd0);

  always_comb begin
    nxt_o = cur_i;
    if (cin_i) begin
      if (dir_i) nxt_o = at_max  ? 4'd0 : cur_i + 4'd1;
      else       nxt_o = at_zero ? MAXV : cur_i - 4'd1;
    end
  end

  assign term_o  = dir_i ? at_max : at_zero;
  assign nterm_o = dir_i ? (nxt_o == MAXV) : (nxt_o == 4'd0);
  assign clamp_o = (ld_i > MAXV) ? MAXV : ld_i;
endmodule

module bcd_timer_updown #(
  parameter int                  DIGITS    = 4,
  parameter logic [4*DIGITS-1:0] DIGIT_MOD = 16'h6A6A
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  input  logic                enable_n,
  input  logic                dir,
  output logic [4*DIGITS-1:0] count,
  output logic                tc_n,
  output logic                done
);
  logic [DIGITS-1:0][3:0] count_q, count_d, nxt, clamp;
  logic [DIGITS-1:0]      term, nterm, cy;
  logic                   done_q, done_d;

  // A digit steps when every lower digit is at its wrap point (carry/borrow chain).
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    if (i == 0) begin : g_c0
      assign cy[i] = 1'b1;
    end else begin : g_cn
      assign cy[i] = cy[i-1] & term[i-1];
    end
    bcd_timer_digit #(.MOD(DIGIT_MOD[4*i +: 4])) u_dig (
      .dir_i   (dir),
      .cin_i   (cy[i]),
      .cur_i   (count_q[i]),
      .ld_i    (load_value[4*i +: 4]),
      .nxt_o   (nxt[i]),
      .clamp_o (clamp[i]),
      .term_o  (term[i]),
      .nterm_o (nterm[i])
    );
  end

  assign tc_n  = ~&term;
  assign count = count_q;
  assign done  = done_q;

`ifdef BCD_TIMER_AUTO_RELOAD_EN
  logic [DIGITS-1:0][3:0] reload_q, reload_d;
`endif

  always_comb begin
    count_d = count_q;
    done_d  = 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (load) begin
      count_d = clamp;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
      reload_d = clamp;
`endif
    end else if (!enable_n) begin
      if (tc_n) begin
        count_d = nxt;
        done_d  = &nterm;
      end
`ifdef BCD_TIMER_AUTO_RELOAD_EN
      // Terminal in down mode restarts the period; reload of 0 just stays at 0.
      else if (!dir) begin
        count_d = reload_q;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      done_q  <= 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end
endmodule

// File: tb/tb_bcd_timer_updown.sv
// Bench for bcd_timer_updown: directed steps plus random traffic against an integer-valued model.
module tb_bcd_timer_updown;
  localparam int          DIGITS    = 4;
  localparam logic [15:0] DIGIT_MOD = 16'h6A6A;

  logic        clk = 1'b0;
  logic        rst, load, enable_n, dir;
  logic [15:0] load_value, count;
  logic        tc_n, done;

  int vectors = 0, miscompares = 0;
  int m_val = 0, m_reload = 0;
  logic m_done = 1'b0;

  bcd_timer_updown #(.DIGITS(DIGITS), .DIGIT_MOD(DIGIT_MOD)) dut (
    .clk(clk), .rst(rst), .load(load), .load_value(load_value),
    .enable_n(enable_n), .dir(dir), .count(count), .tc_n(tc_n), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int md(int i);
    logic [15:0] m;
    m = DIGIT_MOD;
    return int'(m[4*i +: 4]);
  endfunction

  function automatic int total();
    int t = 1;
    for (int i = 0; i < DIGITS; i++) t *= md(i);
    return t;
  endfunction

  // Packed digits -> position in the mixed-radix sequence.
  function automatic int to_int(logic [15:0] p);
    int v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * md(i) + int'(p[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] p = '0;
    for (int i = 0; i < DIGITS; i++) begin
      p[4*i +: 4] = 4'(v % md(i));
      v = v / md(i);
    end
    return p;
  endfunction

  function automatic logic [15:0] clampv(logic [15:0] p);
    logic [15:0] r = p;
    for (int i = 0; i < DIGITS; i++)
      if (int'(p[4*i +: 4]) > md(i) - 1) r[4*i +: 4] = 4'(md(i) - 1);
    return r;
  endfunction

  function automatic bit is_term(int v, logic d);
    return d ? (v == total() - 1) : (v == 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance model with the inputs presented to this edge, clock, then compare.
  task automatic step(input string tag);
    if (!rst) begin
      m_val = 0; m_done = 1'b0; m_reload = 0;
    end else if (load) begin
      m_val = to_int(clampv(load_value)); m_reload = m_val; m_done = 1'b0;
    end else if (!enable_n) begin
      if (!is_term(m_val, dir)) begin
        m_val  = dir ? m_val + 1 : m_val - 1;
        m_done = is_term(m_val, dir);
      end else begin
        m_done = 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
        if (!dir) m_val = m_reload;
`endif
      end
    end else begin
      m_done = 1'b0;
    end
    @(posedge clk);
    #1;
    chk({tag, ".count"}, count, to_bcd(m_val));
    chk({tag, ".done"}, done, m_done);
    chk({tag, ".tc_n"}, tc_n, !is_term(m_val, dir));
  endtask

  task automatic do_load(input logic [15:0] v, input logic d);
    load = 1'b1; load_value = v; dir = d; step("load"); load = 1'b0;
  endtask

  initial begin
    rst = 1'b0; load = 1'b1; load_value = 16'h1234; enable_n = 1'b1; dir = 1'b0;
    step("reset");
    chk("reset_count", count, 16'h0000);
    chk("reset_done", done, 1'b0);
    chk("reset_tcn", tc_n, 1'b0);
    rst = 1'b1;

    // Down count through a minute boundary to terminal, then saturate.
    do_load(16'h0100, 1'b0);
    chk("ld0100", count, 16'h0100);
    enable_n = 1'b0;
    step("dn1"); chk("dn_0059", count, 16'h0059);
    step("dn2"); chk("dn_0058", count, 16'h0058);
    for (int i = 0; i < 58; i++) step("dn");
    chk("dn_zero", count, 16'h0000);
    chk("dn_done", done, 1'b1);
    chk("dn_tcn", tc_n, 1'b0);
    step("dn_hold");
`ifndef BCD_TIMER_AUTO_RELOAD_EN
    chk("dn_sat", count, 16'h0000);
`endif
    chk("dn_hold_done", done, 1'b0);

    // Up count to 59:59 and saturate.
    enable_n = 1'b1;
    do_load(16'h5958, 1'b1);
    enable_n = 1'b0;
    step("up1"); chk("up_5959", count, 16'h5959); chk("up_done", done, 1'b1);
    step("up2"); chk("up_sat", count, 16'h5959); chk("up_sat_done", done, 1'b0);

    // Clamp, and load wins over enable.
    do_load(16'h9F7C, 1'b0);
    chk("clamp", count, 16'h5959); chk("clamp_done", done, 1'b0);

    // Dir change that makes the count terminal: tc_n drops with no edge, then hold.
    dir = 1'b1; #1;
    chk("dir_tcn", tc_n, 1'b0);
    step("dir_hold"); chk("dir_hold_cnt", count, 16'h5959); chk("dir_hold_done", done, 1'b0);

    // Reset mid-count abandons without done.
    do_load(16'h0003, 1'b0);
    step("mid"); chk("mid_0002", count, 16'h0002);
    rst = 1'b0; step("mid_rst"); rst = 1'b1;
    chk("mid_rst_cnt", count, 16'h0000); chk("mid_rst_done", done, 1'b0);

    // Direction reversal mid-count.
    do_load(16'h0003, 1'b0);
    step("rev");
    dir = 1'b1; step("rev_up"); chk("rev_0003", count, 16'h0003);

`ifdef BCD_TIMER_AUTO_RELOAD_EN
    do_load(16'h0002, 1'b0);
    step("ar1"); chk("ar_0001", count, 16'h0001);
    step("ar2"); chk("ar_0000", count, 16'h0000); chk("ar_done1", done, 1'b1);
    step("ar3"); chk("ar_0002", count, 16'h0002); chk("ar_nodone", done, 1'b0);
    step("ar4"); chk("ar_0001b", count, 16'h0001);
    step("ar5"); chk("ar_0000b", count, 16'h0000); chk("ar_done2", done, 1'b1);
`endif

    // Random traffic; loads are biased toward values near both terminals.
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 79) != 0);
      load     = ($urandom_range(0, 24) == 0);
      enable_n = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 39) == 0) dir = ~dir;
      case ($urandom_range(0, 2))
        0:       load_value = 16'($urandom);
        1:       load_value = to_bcd($urandom_range(0, 8));
        default: load_value = to_bcd(total() - 1 - $urandom_range(0, 8));
      endcase
      step("rnd");
    end
    load = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
